// File: rtl/fir_mac_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sched_if
// Purpose  : Sample-in, result-out and coefficient-port bundle of fir_mac_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sched_if #(
    parameter int WIDTH_H = 5,
    parameter int WIDTH_W = 20,
    parameter int LOG_N   = 5
);
    localparam int c_dw = WIDTH_H + WIDTH_W;

    logic                    data_i_en;
    logic                    data_i_rdy;
    logic signed [c_dw-1:0]  data_i;
    logic                    data_o_en;
    logic signed [c_dw-1:0]  data_o;
    logic                    coef_we;
    logic        [LOG_N:0]   coef_addr;
    logic signed [c_dw-1:0]  coef_data;
    logic                    coef_err;
    logic                    clear;
    logic                    busy;

    modport master (
        output data_i_en, data_i, coef_we, coef_addr, coef_data, clear,
        input  data_i_rdy, data_o_en, data_o, coef_err, busy
    );

    modport slave (
        input  data_i_en, data_i, coef_we, coef_addr, coef_data, clear,
        output data_i_rdy, data_o_en, data_o, coef_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sched
// Purpose  : Time-multiplexed FIR; one shared MAC walks the N+1 taps per sample.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sched #(
    parameter int WIDTH_H = 5,
    parameter int WIDTH_W = 20,
    parameter int N       = 32,
    parameter int LOG_N   = 5
) (
    input  wire              clk,
    input  wire              rst,
    fir_mac_sched_if.slave   bus
);
    localparam int c_dw = WIDTH_H + WIDTH_W;
    localparam int c_pw = 2 * c_dw;
    localparam int c_aw = LOG_N + 1;

    localparam logic [c_aw-1:0] c_last  = c_aw'(N);
    localparam logic [c_aw-1:0] c_taps  = c_aw'(N + 1);
    localparam logic [c_aw-1:0] c_inc   = c_aw'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mac  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [N:0][c_dw-1:0]      r_hist;
    logic [N:0][c_dw-1:0]      r_coef;
    logic [c_aw-1:0]           r_wr_ptr;
    logic [c_aw-1:0]           r_k;
    logic [c_aw-1:0]           w_idx;
    logic signed [c_dw-1:0]    r_acc;
    logic signed [c_dw-1:0]    r_data_o;
    logic                      r_coef_err;
    logic signed [c_dw-1:0]    w_a;
    logic signed [c_dw-1:0]    w_b;
    logic signed [c_pw-1:0]    w_prod;
    logic signed [c_dw-1:0]    w_term;
    logic signed [c_dw-1:0]    w_acc_nxt;
    logic                      w_coef_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (bus.data_i_en) w_state_nxt = c_mac;
            c_mac:   if (r_k == c_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // History is a circular buffer of N+1 entries: newest-minus-k wraps modulo N+1.
    assign w_idx = (r_wr_ptr >= r_k) ? (r_wr_ptr - r_k) : (r_wr_ptr + c_taps - r_k);

    assign w_a       = r_hist[w_idx];
    assign w_b       = r_coef[r_k];
    assign w_prod    = c_pw'(w_a) * c_pw'(w_b);
    assign w_term    = c_dw'(w_prod >>> WIDTH_W);
    assign w_acc_nxt = r_acc + w_term;

    assign w_coef_ok = bus.coef_we && (r_state == c_idle) && (bus.coef_addr <= c_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist     <= '0;
            r_coef     <= '0;
            r_wr_ptr   <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_data_o   <= '0;
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= bus.coef_we && !w_coef_ok;
            if (w_coef_ok) begin
                r_coef[bus.coef_addr] <= bus.coef_data;
            end
            case (r_state)
                c_idle: begin
                    if (bus.data_i_en) begin
                        r_hist[r_wr_ptr] <= bus.data_i;
                        r_acc            <= '0;
                        r_k              <= '0;
                    end else if (bus.clear) begin
                        r_hist   <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                c_mac: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + c_inc;
                    // Result is captured on entry to DONE so it is valid with the pulse.
                    if (r_k == c_last) begin
                        r_data_o <= w_acc_nxt;
                        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_i_rdy = (r_state == c_idle);
    assign bus.busy       = (r_state != c_idle);
    assign bus.data_o_en  = (r_state == c_done);
    assign bus.data_o     = r_data_o;
    assign bus.coef_err   = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sched
// Purpose  : Self-checking bench for fir_mac_sched with a tap-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sched;
    localparam int WIDTH_H = 5;
    localparam int WIDTH_W = 20;
    localparam int N       = 32;
    localparam int LOG_N   = 5;
    localparam int c_dw    = WIDTH_H + WIDTH_W;
    localparam longint c_one = 64'd1 << WIDTH_W;

    typedef struct { longint din; longint dout; } vec_t;
    typedef struct { longint val; int due; } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fir_mac_sched_if #(.WIDTH_H(WIDTH_H), .WIDTH_W(WIDTH_W), .LOG_N(LOG_N)) ifc ();

    fir_mac_sched #(.WIDTH_H(WIDTH_H), .WIDTH_W(WIDTH_W), .N(N), .LOG_N(LOG_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint wrap(input longint v);
        logic signed [c_dw-1:0] t;
        t = v[c_dw-1:0];
        return longint'(t);
    endfunction

    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = a * b;
        return wrap(p >>> WIDTH_W);
    endfunction

    // Reference model: newest sample at m_hist[0], output = sum of tap products.
    longint m_coef [0:N];
    longint m_hist [$];
    exp_t   exp_q [$];
    int     m_next_idle = 0;
    bit     err_exp = 1'b0;

    function automatic void model_reset();
        for (int k = 0; k <= N; k++) m_coef[k] = 0;
        m_hist.delete();
        for (int k = 0; k <= N; k++) m_hist.push_back(0);
        exp_q.delete();
        m_next_idle = 0;
        err_exp = 1'b0;
    endfunction

    always @(negedge clk) begin : p_mon
        bit     idle;
        longint y;
        exp_t   e;
        if (!rst) begin
            model_reset();
        end else begin
            idle = (cyc >= m_next_idle);
            chk("data_i_rdy", ifc.data_i_rdy, idle);
            chk("busy", ifc.busy, !idle);
            chk("coef_err", ifc.coef_err, err_exp);
            err_exp = ifc.coef_we && !(idle && int'(ifc.coef_addr) <= N);
            if (ifc.coef_we && idle && int'(ifc.coef_addr) <= N)
                m_coef[int'(ifc.coef_addr)] = ifc.coef_data;
            if (idle && ifc.data_i_en) begin
                m_hist.push_front(ifc.data_i);
                void'(m_hist.pop_back());
                y = 0;
                for (int k = 0; k <= N; k++) y = wrap(y + mulq(m_hist[k], m_coef[k]));
                e.val = y;
                e.due = cyc + N + 2;
                exp_q.push_back(e);
                m_next_idle = cyc + N + 3;
            end else if (idle && ifc.clear) begin
                for (int k = 0; k <= N; k++) m_hist[k] = 0;
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("data_o_en_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (ifc.data_o_en) begin
                if (exp_q.size() == 0) begin
                    chk("data_o_en_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_o", ifc.data_o, e.val);
                    chk("data_o_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!ifc.data_i_rdy && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("rdy_timeout", 0, 1);
    endtask

    task automatic start_sample(input longint x);
        wait_idle();
        ifc.data_i    = c_dw'(x);
        ifc.data_i_en = 1'b1;
        step();
        ifc.data_i_en = 1'b0;
    endtask

    task automatic get_output(output longint y, output int lat);
        lat = 1;
        while (!ifc.data_o_en && lat < 100) begin
            step();
            lat++;
        end
        y = ifc.data_o;
    endtask

    task automatic send_get(input longint x, output longint y);
        int lat;
        start_sample(x);
        get_output(y, lat);
        chk("latency", lat, N + 2);
    endtask

    task automatic load_coef(input bit ramp, input longint v);
        wait_idle();
        for (int k = 0; k <= N; k++) begin
            ifc.coef_we   = 1'b1;
            ifc.coef_addr = (LOG_N+1)'(k);
            ifc.coef_data = ramp ? c_dw'(k + 1) : c_dw'(v);
            step();
        end
        ifc.coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        wait_idle();
        ifc.clear = 1'b1;
        step();
        ifc.clear = 1'b0;
    endtask

    initial begin : p_main
        vec_t   imp_tab [0:N+1];
        longint y;
        longint term;
        int     lat, n_acc, n_low, n_out;

        imp_tab[0].din  = c_one;
        imp_tab[0].dout = 1;
        for (int i = 1; i <= N; i++) begin
            imp_tab[i].din  = 0;
            imp_tab[i].dout = i + 1;
        end
        imp_tab[N+1].din  = 0;
        imp_tab[N+1].dout = 0;

        ifc.data_i_en = 1'b0; ifc.data_i = '0; ifc.coef_we = 1'b0;
        ifc.coef_addr = '0;   ifc.coef_data = '0; ifc.clear = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        chk("reset_data_o_en", ifc.data_o_en, 0);
        chk("reset_data_o", ifc.data_o, 0);
        chk("reset_coef_err", ifc.coef_err, 0);
        chk("reset_busy", ifc.busy, 0);
        chk("reset_rdy", ifc.data_i_rdy, 1);
        rst = 1'b1;
        step();

        // Impulse through ramp coefficients.
        load_coef(1'b1, 0);
        for (int i = 0; i <= N + 1; i++) begin
            send_get(imp_tab[i].din, y);
            chk("impulse", y, imp_tab[i].dout);
        end

        // DC gain, also wraps the write pointer.
        load_coef(1'b0, 64'd1 << 15);
        pulse_clear();
        for (int i = 1; i <= 40; i++) begin
            send_get(c_one, y);
            chk("dc_gain", y, longint'((i <= N + 1) ? i : N + 1) * 32768);
        end

        // Handshake with data_i_en held high.
        wait_idle();
        ifc.data_i_en = 1'b1;
        n_acc = 0; n_low = 0; n_out = 0;
        for (int i = 0; i < 4 * (N + 3); i++) begin
            ifc.data_i = c_dw'($urandom);
            if (ifc.data_i_rdy) n_acc++; else n_low++;
            if (ifc.data_o_en) n_out++;
            step();
        end
        ifc.data_i_en = 1'b0;
        chk("hs_accepts", n_acc, 4);
        chk("hs_rdy_low", n_low, 4 * (N + 2));
        chk("hs_outputs", n_out, n_acc);

        // Coefficient guard.
        start_sample(c_dw'($urandom));
        ifc.coef_we = 1'b1; ifc.coef_addr = '0; ifc.coef_data = 25'd123;
        step();
        ifc.coef_we = 1'b0;
        chk("err_busy_write", ifc.coef_err, 1);
        get_output(y, lat);
        pulse_clear();
        send_get(c_one, y);
        chk("coef_kept", y, 32768);
        wait_idle();
        ifc.coef_we = 1'b1; ifc.coef_addr = 6'd33; ifc.coef_data = 25'd5;
        step();
        ifc.coef_we = 1'b0;
        chk("err_bad_addr", ifc.coef_err, 1);
        wait_idle();
        ifc.coef_we = 1'b1; ifc.coef_addr = '0; ifc.coef_data = c_dw'(3 * c_one);
        step();
        ifc.coef_we = 1'b0;
        chk("err_valid_write", ifc.coef_err, 0);
        pulse_clear();
        send_get(c_one, y);
        chk("coef_new", y, 3 * c_one);

        // Reset at tap 10 of a MAC pass.
        load_coef(1'b1, 0);
        start_sample(c_one);
        repeat (10) step();
        rst = 1'b0;
        #1;
        chk("rst_data_o_en", ifc.data_o_en, 0);
        chk("rst_data_o", ifc.data_o, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_coef_err", ifc.coef_err, 0);
        chk("rst_rdy", ifc.data_i_rdy, 1);
        n_out = 0;
        repeat (40) begin
            step();
            if (ifc.data_o_en) n_out++;
        end
        chk("rst_no_pulse", n_out, 0);
        rst = 1'b1;
        step();
        load_coef(1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            send_get((i == 0) ? c_one : 0, y);
            chk("rst_impulse", y, i + 1);
        end

        // Accumulator wrap with maximal operands, then clear.
        load_coef(1'b0, 64'h0F_FFFF);
        pulse_clear();
        term = mulq(64'hFF_FFFF, 64'h0F_FFFF);
        for (int i = 1; i <= 3; i++) begin
            send_get(64'hFF_FFFF, y);
            chk("overflow", y, wrap(i * term));
        end
        pulse_clear();
        load_coef(1'b1, 0);
        send_get(c_one, y);
        chk("clear_impulse0", y, 1);
        send_get(0, y);
        chk("clear_impulse1", y, 2);

        // Randomized traffic against the model.
        wait_idle();
        for (int i = 0; i < 1500; i++) begin
            ifc.data_i_en = ($urandom_range(0, 2) == 0);
            ifc.data_i    = c_dw'($urandom);
            ifc.coef_we   = ($urandom_range(0, 7) == 0);
            ifc.coef_addr = 6'($urandom_range(0, 40));
            ifc.coef_data = c_dw'($urandom);
            ifc.clear     = ($urandom_range(0, 19) == 0);
            step();
        end
        ifc.data_i_en = 1'b0; ifc.coef_we = 1'b0; ifc.clear = 1'b0;
        repeat (40) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Time-multiplexed FIR controller. It sequences one shared multiply-accumulate datapath across the N+1 taps of a filter.
- Trades throughput for area: one output per N+3 clocks, against N+1 multipliers in the fully parallel FIR.
- Holds the sample history and a run-time-loadable coefficient bank.
- Sits between the sample source and downstream logic, with the same data format and the same fixed-point rules as the team's parallel FIR.

Parameters:
- width_H, 5, integer bits of the signed fixed-point word.
- width_W, 20, fraction bits; 1.0 = 2^20.
- N, 32, filter order; there are N+1 taps.
- log_N, 5, ceil(log2(N)). Tap index and address width is log_N+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_i_en  in  1  input sample valid.
- data_i_rdy  out  1  block can accept a sample.
- data_i  in  width_H+width_W  signed input sample.
- data_o_en  out  1  one-cycle output valid pulse.
- data_o  out  width_H+width_W  signed filter output.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log_N+1  tap index 0..N.
- coef_data  in  width_H+width_W  signed coefficient.
- coef_err  out  1  one-cycle pulse: the coefficient write was dropped.
- clear  in  1  zero the sample history.
- busy  out  1  high while in MAC or DONE.

Behaviour:
- Reset (rst=0, async), all of the following are zero:
  - outputs: data_o_en, data_o, coef_err, busy.
  - data_i_rdy=1 once the block is in IDLE.
  - all state: history, coefficients, wr_ptr, tap counter, accumulator, FSM=IDLE.
- Reset mid-MAC aborts the operation. No output pulse is produced, and history is lost.
- State machine: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - data_i_rdy=1, busy=0.
  - If data_i_en=1: write data_i to hist[wr_ptr], clear the accumulator, set k=0, go to MAC.
  - If clear=1 and data_i_en=0: zero all hist and set wr_ptr=0.
  - If clear and data_i_en are both high: the sample wins and clear is ignored.
- MAC (N+1 cycles, k=0..N):
  - acc <= acc + mul(hist[(wr_ptr-k) mod (N+1)], coef[k]). After k=N, go to DONE.
- mul rule:
  - full signed product of 2*(width_H+width_W) bits.
  - arithmetic shift right by width_W.
  - truncate to width_H+width_W.
- acc is width_H+width_W bits and wraps (two's-complement modulo, no saturation). The result is bit-exact with the parallel FIR for identical coefficients.
- History index wrap is modulo N+1, not a power of two:
  - (0-1) maps to N.
  - wr_ptr advances 0..N then back to 0.
  - wr_ptr increments on entering DONE.
- DONE (1 cycle): data_o <= acc, data_o_en=1, go to IDLE.
- data_o holds its value until the next DONE.
- Latency: sample accepted at cycle t, data_o_en high at cycle t+N+2. Throughput is 1 sample per N+3 cycles.
- data_i_rdy=0 in MAC and DONE. data_i_en while not ready is ignored; no sample is lost into history.
- Coefficient writes:
  - Accepted only in IDLE with coef_addr<=N; the new value takes effect on the next sample.
  - A write during busy, or with coef_addr>N, is dropped and coef_err pulses high the following cycle.
  - A write in the same IDLE cycle as an accepted sample is accepted and applies to that sample's MAC.

Test Plan:
- Impulse: load coef[k]=k+1 (raw). Feed 2^20, then 32 zeros -> data_o = 1, 2, ..., 33, then the next output is 0. Each data_o_en arrives exactly N+2 cycles after its accept.
- DC gain with all coefficients 2^15 (1/32 raw): feed 2^20 continuously -> output ramps to 33*2^15 = 1081344 by the 33rd output and stays constant. This exercises wr_ptr wrap 32->0.
- Handshake: hold data_i_en=1 constantly -> only one sample per 35 cycles is accepted. data_i_rdy is low for 34 of every 35 cycles, and the number of outputs equals the number of accepts.
- Coefficient guard:
  - coef_we during MAC -> coef_err pulse, coefficient unchanged.
  - coef_addr=33 in IDLE -> coef_err pulse.
  - valid write in IDLE -> coef_err=0 and the next output reflects the new value.
- Reset mid-MAC: assert rst at k=10 -> all outputs 0 immediately. No data_o_en pulse. After release, an impulse reproduces the coefficient sequence from zeroed history, coefficients being reloaded.
- Overflow wrap: all coefficients 0x0F_FFFF with maximal positive input -> data_o equals the 25-bit modular sum. Assert clear in IDLE -> the next impulse response starts from zero history.
